// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported instruction/data memory between
// the fetch path and the load/store path. Only one access is outstanding at a
// time. Each access runs a request/acknowledge handshake with the memory, and a
// timeout aborts an access that the memory never acknowledges.
// Optional feature: define ARB_ROUND_ROBIN_EN to alternate the grant between the
// two sides when both request together. If it is undefined, data always has
// priority over fetch.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                  rclk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic [DATA_W-1:0]     if_rdata,
    output logic                  if_ack,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [DATA_W/8-1:0]   d_be,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  d_ack,
    output logic                  m_req,
    output logic                  m_we,
    output logic [DATA_W/8-1:0]   m_be,
    output logic [ADDR_W-1:0]     m_addr,
    output logic [DATA_W-1:0]     m_wdata,
    input  logic [DATA_W-1:0]     m_rdata,
    input  logic                  m_ack,
    output logic                  err,
    output logic                  stall
);

    localparam int         BE_W     = DATA_W / 8;
    // The last busy cycle that may still complete. A later cycle aborts the access.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        D_BUSY  = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t              state_q,    state_d;
    logic [7:0]          cnt_q,      cnt_d;
    logic [ADDR_W-1:0]   addr_q,     addr_d;
    logic [DATA_W-1:0]   wdata_q,    wdata_d;
    logic                we_q,       we_d;
    logic [BE_W-1:0]     be_q,       be_d;
    logic                m_req_q,    m_req_d;
    logic                if_ack_q,   if_ack_d;
    logic                d_ack_q,    d_ack_d;
    logic                err_q,      err_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q,  d_rdata_d;
    logic                grant_data_s;
`ifdef ARB_ROUND_ROBIN_EN
    logic                last_data_q, last_data_d;   // 1 = data served last, 0 = fetch
`endif

    // Grant selection: decide whether the data side wins the next IDLE grant.
    always_comb begin
        grant_data_s = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        if (d_req && (!if_req || !last_data_q)) begin
            grant_data_s = 1'b1;
        end else begin
            grant_data_s = 1'b0;
        end
`else
        if (d_req) begin
            grant_data_s = 1'b1;
        end else begin
            grant_data_s = 1'b0;
        end
`endif
    end

    // Next-state logic: sequence grant, memory handshake or timeout, and response.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        be_d       = be_q;
        m_req_d    = 1'b0;
        if_ack_d   = 1'b0;
        d_ack_d    = 1'b0;
        err_d      = 1'b0;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_data_d = last_data_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant_data_s) begin
                    state_d = D_BUSY;
                    m_req_d = 1'b1;
                    addr_d  = d_addr;
                    wdata_d = d_wdata;
                    we_d    = d_we;
                    be_d    = d_be;
`ifdef ARB_ROUND_ROBIN_EN
                    last_data_d = 1'b1;
`endif
                end else if (if_req) begin
                    state_d = IF_BUSY;
                    m_req_d = 1'b1;
                    addr_d  = if_addr;
                    wdata_d = '0;
                    we_d    = 1'b0;
                    be_d    = '0;
`ifdef ARB_ROUND_ROBIN_EN
                    last_data_d = 1'b0;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            IF_BUSY, D_BUSY: begin
                cnt_d = cnt_q + 8'd1;
                if (m_ack) begin
                    // The memory answered, so capture the word for the side that owns the access.
                    state_d = RESP;
                    if (state_q == D_BUSY) begin
                        d_ack_d   = 1'b1;
                        d_rdata_d = m_rdata;
                    end else begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = m_rdata;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    // The access timed out. Complete it with an error and zero data.
                    state_d = RESP;
                    err_d   = 1'b1;
                    if (state_q == D_BUSY) begin
                        d_ack_d   = 1'b1;
                        d_rdata_d = '0;
                    end else begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = '0;
                    end
                end else begin
                    m_req_d = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // State and output registers, cleared asynchronously on reset.
    always_ff @(posedge rclk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            be_q       <= '0;
            m_req_q    <= 1'b0;
            if_ack_q   <= 1'b0;
            d_ack_q    <= 1'b0;
            err_q      <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_data_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            be_q       <= be_d;
            m_req_q    <= m_req_d;
            if_ack_q   <= if_ack_d;
            d_ack_q    <= d_ack_d;
            err_q      <= err_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_data_q <= last_data_d;
`endif
        end
    end

    assign m_req    = m_req_q;
    assign m_addr   = addr_q;
    assign m_wdata  = wdata_q;
    assign m_we     = we_q;
    assign m_be     = be_q;
    assign if_ack   = if_ack_q;
    assign d_ack    = d_ack_q;
    assign err      = err_q;
    assign if_rdata = if_rdata_q;
    assign d_rdata  = d_rdata_q;
    // Stall falls in the ack cycle itself because the ack masks the held request.
    assign stall    = (if_req & ~if_ack_q) | (d_req & ~d_ack_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter (TIMEOUT = 4). It runs directed
// accesses first and then random ones. A reference model derives the grant
// order, the handshake length and the response from the arbitration rules.
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int TO = 4;

    logic          rclk = 1'b0;
    logic          rst;
    logic          if_req, d_req, d_we, m_req, m_we, m_ack, if_ack, d_ack, err, stall;
    logic [AW-1:0] if_addr, d_addr, m_addr;
    logic [DW-1:0] if_rdata, d_rdata, d_wdata, m_wdata, m_rdata;
    logic [BW-1:0] d_be, m_be;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .rclk(rclk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ack(m_ack),
        .err(err), .stall(stall)
    );

    always #5 rclk = ~rclk;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    // Transaction descriptors for the two requesters.
    logic [AW-1:0] f_addr_v, d_addr_v;
    logic [DW-1:0] f_mem_v, d_mem_v, d_wdata_v;
    logic          d_we_v;
    logic [BW-1:0] d_be_v;
    int            f_waits, d_waits;

    // Reference-model state.
    logic [DW-1:0] exp_if_rdata = '0;
    logic [DW-1:0] exp_d_rdata  = '0;
    bit            last_data    = 1'b0;
    bit            pend_f, pend_d;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_m_req"}, m_req, 1'b0);
        check({tag, "_if_ack"}, if_ack, 1'b0);
        check({tag, "_d_ack"}, d_ack, 1'b0);
        check({tag, "_err"}, err, 1'b0);
    endtask

    // Serve one side's access from its first busy cycle through its ack cycle.
    task automatic serve_side(input bit side_d);
        int   waits;
        int   len;
        bit   to;
        waits = side_d ? d_waits : f_waits;
        to    = (waits >= TO);
        len   = to ? TO : waits + 1;
        for (int k = 0; k < len; k++) begin
            @(negedge rclk);
            m_ack   = 1'b0;
            m_rdata = $urandom;
            check("busy_m_req", m_req, 1'b1);
            check("busy_m_addr", m_addr, side_d ? d_addr_v : f_addr_v);
            check("busy_m_we", m_we, side_d ? d_we_v : 1'b0);
            check("busy_m_be", m_be, side_d ? d_be_v : '0);
            if (side_d) check("busy_m_wdata", m_wdata, d_wdata_v);
            check("busy_acks", {if_ack, d_ack, err}, 3'b000);
            check("busy_stall", stall, 1'b1);
            if (!to && k == waits) begin
                m_ack   = 1'b1;
                m_rdata = side_d ? d_mem_v : f_mem_v;
            end
        end
        @(negedge rclk);
        m_ack   = 1'b0;
        m_rdata = $urandom;
        if (side_d) exp_d_rdata  = to ? '0 : d_mem_v;
        else        exp_if_rdata = to ? '0 : f_mem_v;
        check("ack_if_ack", if_ack, !side_d);
        check("ack_d_ack", d_ack, side_d);
        check("ack_err", err, to);
        check("ack_m_req", m_req, 1'b0);
        check("ack_if_rdata", if_rdata, exp_if_rdata);
        check("ack_d_rdata", d_rdata, exp_d_rdata);
        check("ack_stall", stall, (pend_f && side_d) || (pend_d && !side_d));
        if (side_d) begin d_req = 1'b0; pend_d = 1'b0; end
        else        begin if_req = 1'b0; pend_f = 1'b0; end
        last_data = side_d;
        // A late acknowledge from the memory after an abort must be ignored.
        if (to) m_ack = 1'b1;
    endtask

    // Run one access, or a pair of simultaneous accesses, starting in IDLE.
    task automatic run_access(input bit f_en, input bit d_en);
        bit first_d;
        @(negedge rclk);
        m_ack   = 1'b0;
        m_rdata = $urandom;
        check_quiet("idle");
        if_req  = f_en;
        if_addr = f_addr_v;
        d_req   = d_en;
        d_addr  = d_addr_v;
        d_we    = d_we_v;
        d_be    = d_be_v;
        d_wdata = d_wdata_v;
        pend_f  = f_en;
        pend_d  = d_en;
        #1;
        check("stall_rise", stall, f_en | d_en);
`ifdef ARB_ROUND_ROBIN_EN
        first_d = d_en && (!f_en || !last_data);
`else
        first_d = d_en;
`endif
        if (f_en || d_en) serve_side(first_d);
        if (f_en && d_en) begin
            @(negedge rclk);
            m_ack = 1'b0;
            check_quiet("between");
            check("between_stall", stall, 1'b1);
            serve_side(!first_d);
        end
    endtask

    task automatic set_fetch(input logic [AW-1:0] a, input logic [DW-1:0] mem, input int w);
        f_addr_v = a; f_mem_v = mem; f_waits = w;
    endtask

    task automatic set_data(input logic we, input logic [BW-1:0] be, input logic [AW-1:0] a,
                            input logic [DW-1:0] wd, input logic [DW-1:0] mem, input int w);
        d_we_v = we; d_be_v = be; d_addr_v = a; d_wdata_v = wd; d_mem_v = mem; d_waits = w;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int fe, de;
        rst = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_be = '0;
        if_addr = '0; d_addr = '0; d_wdata = '0; m_ack = 1'b0; m_rdata = '0;
        set_fetch(32'h0, 32'h0, 0);
        set_data(1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 0);
        #3;
        check("rst_outputs", {m_req, if_ack, d_ack, err, m_we, stall}, 6'b000000);
        check("rst_fields", {m_addr, m_be, m_wdata}, 68'h0);
        check("rst_rdata", {if_rdata, d_rdata}, 64'h0);
        @(negedge rclk);
        rst = 1'b1;

        // Single fetch with a zero-wait memory.
        set_fetch(32'h10, 32'h0050_0093, 0);
        run_access(1'b1, 1'b0);
        // Store with three wait cycles.
        set_data(1'b1, 4'b0011, 32'h100, 32'hCAFE_BABE, 32'h1234_5678, 3);
        run_access(1'b0, 1'b1);
        // Load with zero waits.
        set_data(1'b0, 4'b1111, 32'h204, 32'h0, 32'hDEAD_BEEF, 0);
        run_access(1'b0, 1'b1);
        // Simultaneous requests.
        set_fetch(32'h14, 32'h1111_2222, 1);
        set_data(1'b0, 4'b1111, 32'h300, 32'h0, 32'h3333_4444, 2);
        run_access(1'b1, 1'b1);
        // Fetch timeout.
        set_fetch(32'h18, 32'h5555_6666, 7);
        run_access(1'b1, 1'b0);
        // Load that completes on the last permitted cycle.
        set_data(1'b0, 4'b1111, 32'h304, 32'h0, 32'h7777_8888, TO - 1);
        run_access(1'b0, 1'b1);
        // Load timeout.
        set_data(1'b0, 4'b1111, 32'h308, 32'h0, 32'h9999_AAAA, TO);
        run_access(1'b0, 1'b1);

        // Reset in the middle of a data access.
        set_data(1'b1, 4'b1100, 32'h400, 32'hABCD_EF01, 32'h0, 2);
        @(negedge rclk);
        d_req = 1'b1; d_addr = d_addr_v; d_we = d_we_v; d_be = d_be_v; d_wdata = d_wdata_v;
        @(negedge rclk);
        check("mid_busy", m_req, 1'b1);
        #2;
        rst = 1'b0; d_req = 1'b0;
        #1;
        check("mid_rst_outputs", {m_req, if_ack, d_ack, err, m_we, stall}, 6'b000000);
        check("mid_rst_fields", {m_addr, m_be, m_wdata}, 68'h0);
        check("mid_rst_rdata", {if_rdata, d_rdata}, 64'h0);
        exp_if_rdata = '0; exp_d_rdata = '0; last_data = 1'b0;
        @(negedge rclk);
        rst = 1'b1;
        run_access(1'b0, 1'b1);

        // Random traffic.
        for (int i = 0; i < 40; i++) begin
            fe = $urandom_range(0, 1);
            de = (fe == 0) ? 1 : $urandom_range(0, 1);
            set_fetch($urandom, $urandom, $urandom_range(0, 5));
            set_data(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, $urandom,
                     $urandom, $urandom_range(0, 5));
            run_access(fe[0], de[0]);
            if ($urandom_range(0, 3) == 0) begin
                @(negedge rclk);
                m_ack = 1'b0;
                check_quiet("gap");
                check("gap_stall", stall, 1'b0);
            end
        end

        @(negedge rclk);
        m_ack = 1'b0;
        check_quiet("final");
        check("final_stall", stall, 1'b0);
        check("final_rdata", {if_rdata, d_rdata}, {exp_if_rdata, exp_d_rdata});
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer that shares one single-ported unified instruction/data memory between the CPU datapath's instruction-fetch path and its load/store path. It serialises the two request streams and drives the memory through a request/acknowledge handshake with variable latency. A timeout aborts memory accesses that never complete. It produces the pipeline stall the datapath uses to freeze the PC and register-file writes while an access is outstanding.

## Interface
Parameters:
- ADDR_W, 32, byte-address width of all address ports
- DATA_W, 32, data width; byte-enable width is DATA_W/8
- TIMEOUT, 255, maximum cycles in a busy state waiting for m_ack before abort; must be 1..255

Ports:
- Clocking: one clock; reset is asynchronous and active-low.
  - rclk  in  1  clock; all state changes on the rising edge
  - rst  in  1  reset, asynchronous and active-low
- Fetch side:
  - if_req  in  1  fetch request, held until if_ack
  - if_addr  in  ADDR_W  fetch address
  - if_rdata  out  DATA_W  fetched word, valid while if_ack=1
  - if_ack  out  1  one-cycle completion pulse for fetch
- Data side:
  - d_req  in  1  data request, held until d_ack
  - d_we  in  1  1 = store, 0 = load
  - d_be  in  DATA_W/8  store byte enables
  - d_addr  in  ADDR_W  data address
  - d_wdata  in  DATA_W  store data
  - d_rdata  out  DATA_W  load data, valid while d_ack=1
  - d_ack  out  1  one-cycle completion pulse for data
- Memory side:
  - m_req  out  1  memory request, held until m_ack
  - m_we, m_be, m_addr, m_wdata  out  —  forwarded from the granted requester (m_we=0 and m_be=0 for fetch)
  - m_rdata  in  DATA_W  memory read data, valid with m_ack
  - m_ack  in  1  one-cycle completion from memory
- Status:
  - err  out  1  pulses with if_ack/d_ack when the access timed out
  - stall  out  1  (if_req & ~if_ack) | (d_req & ~d_ack), combinational

## Operation
- FSM states: IDLE, IF_BUSY, D_BUSY, RESP.
- IDLE
  - d_req=1 → D_BUSY; else if_req=1 → IF_BUSY; else stay.
  - The grant latches the selected requester's address, data, we and be into internal registers.
- IF_BUSY / D_BUSY
  - m_req=1 and memory fields are driven from the latched registers, stable for the whole state.
  - Timeout counter increments each cycle.
  - m_ack=1 → capture m_rdata into the granted side's rdata register → RESP.
  - Counter reaching TIMEOUT without m_ack → set error flag, rdata ← 0 → RESP; m_req drops.
- RESP
  - Exactly one of if_ack/d_ack is high for one cycle; err is high with it if the error flag is set.
  - Requests are ignored in this state; next state is always IDLE. Counter and error flag clear.
- Requester rules:
  - Fields must stay stable from req rise through the ack cycle.
  - req may be re-asserted for a new access starting the cycle after ack.
- Memory rules:
  - m_ack outside a busy state is ignored.
  - m_ack arriving after a timeout abort is ignored.
- if_rdata and d_rdata hold their last value until overwritten.

## Timing
- Reset values (asynchronous, immediate):
  - FSM = IDLE; m_req = 0; if_ack = d_ack = err = 0.
  - All latched fields, rdata registers and the counter = 0.
- Reset mid-access drops m_req immediately and loses the access; the requester re-issues it.
- Latency with zero-wait memory (m_ack in the first busy cycle):
  - req sampled in IDLE at edge 0; m_req high in cycle 1; ack high in cycle 2.
  - Throughput is one access per 3 cycles.
- Each memory wait cycle adds one cycle of latency.
- A timeout completes TIMEOUT+1 cycles after the grant.
- If both requests are high in IDLE, data wins under fixed priority. The fetch is served next, 3+ cycles later.
- stall falls in the same cycle as the ack.

## Configuration
- Macro ARB_ROUND_ROBIN_EN.
- Defined:
  - A last-grant register (reset = fetch) tracks which side was served last.
  - On simultaneous requests in IDLE, the side not granted last wins.
  - A single request is granted regardless of last-grant.
- Undefined: fixed priority, data over fetch, and no last-grant register.

## Test plan
- Single fetch: if_req=1, if_addr=0x10, memory acks in cycle 1 with 0x00500093 → m_req high in cycle 1 only; if_ack=1 with if_rdata=0x00500093 in cycle 2; err=0.
- Store with waits: d_req=1, d_we=1, d_be=4'b0011, d_addr=0x100, d_wdata=0xCAFEBABE, m_ack after 3 wait cycles → m_* fields stable throughout; d_ack exactly once, 5 cycles after the grant edge.
- Simultaneous requests: both requests high in IDLE.
  - Without the macro: d_ack precedes if_ack.
  - With the macro and last grant = data: if_ack precedes d_ack.
- Timeout: TIMEOUT=4, fetch with m_ack never asserted → m_req high 4 cycles; if_ack=1, err=1, if_rdata=0 on the 5th cycle after the grant. A late m_ack is ignored, and no extra ack occurs.
- Reset mid-access: assert rst=0 in D_BUSY → m_req=0 asynchronously and all outputs reset. After release, d_req is served from IDLE normally.
- Stall: d_req high for 3 waits → stall=1 from req rise until the d_ack cycle; stall=0 when no request is pending.
